// File: rtl/ex_sequencer_if.sv
// ex_sequencer_if: issue, memory and result bus of the execute-stage sequencer.
//   slave  modport: sequencer side (instruction/ack in, ready/mem/result out)
//   master modport: decode/environment side (mirror of slave)
//   issue_valid_i/issue_ready_o  decoded-instruction handshake
//   cond_i, en_*_i, flag_*_i, mem_read_i/mem_write_i, jump_addr_i, alu_flags_i  instruction fields
//   mem_req_o/mem_we_o/mem_ack_i  data memory port
//   wb_valid_o/wb_sel_o, jump_taken_o/jump_addr_o, flags_o, halted_o, err_o  results
interface ex_sequencer_if #(
   parameter int JADDR_BITS = 10
);
   logic                  issue_valid_i;
   logic                  issue_ready_o;
   logic [1:0]            cond_i;
   logic                  en_alu_int_i;
   logic                  en_alu_v_i;
   logic                  en_mem_i;
   logic                  en_jump_i;
   logic                  en_swap_i;
   logic                  flag_end_i;
   logic                  flag_nop_i;
   logic                  mem_read_i;
   logic                  mem_write_i;
   logic [JADDR_BITS-1:0] jump_addr_i;
   logic [3:0]            alu_flags_i;
   logic                  mem_req_o;
   logic                  mem_we_o;
   logic                  mem_ack_i;
   logic                  wb_valid_o;
   logic [2:0]            wb_sel_o;
   logic                  jump_taken_o;
   logic [JADDR_BITS-1:0] jump_addr_o;
   logic [3:0]            flags_o;
   logic                  halted_o;
   logic                  err_o;
   modport slave (
      input  issue_valid_i, cond_i, en_alu_int_i, en_alu_v_i, en_mem_i, en_jump_i, en_swap_i,
             flag_end_i, flag_nop_i, mem_read_i, mem_write_i, jump_addr_i, alu_flags_i, mem_ack_i,
      output issue_ready_o, mem_req_o, mem_we_o, wb_valid_o, wb_sel_o, jump_taken_o, jump_addr_o,
             flags_o, halted_o, err_o
   );
   modport master (
      output issue_valid_i, cond_i, en_alu_int_i, en_alu_v_i, en_mem_i, en_jump_i, en_swap_i,
             flag_end_i, flag_nop_i, mem_read_i, mem_write_i, jump_addr_i, alu_flags_i, mem_ack_i,
      input  issue_ready_o, mem_req_o, mem_we_o, wb_valid_o, wb_sel_o, jump_taken_o, jump_addr_o,
             flags_o, halted_o, err_o
   );
endinterface

// File: rtl/ex_sequencer.sv
// ex_sequencer: execute-stage controller; conditions, sequences and retires one decoded instruction at a time.
//   clk_i  rising-edge clock
//   rst_i  synchronous active-low reset
//   bus    ex_sequencer_if.slave (issue handshake, instruction fields, memory port, results)
//   Optional EX_SEQ_TIMEOUT_EN: abort a memory wait after MEM_TIMEOUT cycles and set sticky err_o.
module ex_sequencer #(
   parameter int VALU_LAT    = 2,
   parameter int JADDR_BITS  = 10,
   parameter int MEM_TIMEOUT = 255
) (
   input logic           clk_i,
   input logic           rst_i,
   ex_sequencer_if.slave bus
);
   localparam int VW = VALU_LAT > 1 ? $clog2(VALU_LAT) : 1;
   typedef enum logic [1:0] {IDLE, VWAIT, MWAIT, HALT} state_t;
   state_t                state, state_nx;
   logic [VW-1:0]         vcnt, vcnt_nx;
   logic                  mem_rd, rd_nx;
   logic                  wb_nx, jmp_nx, we_nx, err_nx;
   logic [2:0]            sel_nx;
   logic [JADDR_BITS-1:0] jaddr_nx;
   logic [3:0]            flags_nx;
   logic                  accept, cond_ok, exec;
`ifdef EX_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(MEM_TIMEOUT + 1);
   logic [TW-1:0]         tcnt, tcnt_nx;
`endif
   assign bus.issue_ready_o = state == IDLE;
   assign accept = bus.issue_valid_i & bus.issue_ready_o;
   // flags_o is {N,Z,C,V}; evaluated against the value held before this instruction
   assign cond_ok = bus.cond_i == 2'd0 ? 1'b1 :
                    bus.cond_i == 2'd1 ? bus.flags_o[2] :
                    bus.cond_i == 2'd2 ? ~bus.flags_o[2] : bus.flags_o[3] ^ bus.flags_o[0];
   assign exec = accept & cond_ok & ~bus.flag_nop_i;
   always_comb begin
      state_nx = state;
      vcnt_nx  = vcnt;
      rd_nx    = mem_rd;
      wb_nx    = 1'b0;
      sel_nx   = bus.wb_sel_o;
      jmp_nx   = 1'b0;
      jaddr_nx = bus.jump_addr_o;
      flags_nx = bus.flags_o;
      we_nx    = bus.mem_we_o;
      err_nx   = bus.err_o;
`ifdef EX_SEQ_TIMEOUT_EN
      tcnt_nx  = tcnt;
`endif
      case (state)
         IDLE:
            if (accept && bus.flag_end_i) state_nx = HALT;
            else if (exec) begin
               if (bus.en_jump_i) begin
                  jmp_nx   = 1'b1;
                  jaddr_nx = bus.jump_addr_i;
               end else if (bus.en_mem_i) begin
                  state_nx = MWAIT;
                  we_nx    = bus.mem_write_i;
                  rd_nx    = bus.mem_read_i;
`ifdef EX_SEQ_TIMEOUT_EN
                  tcnt_nx  = '0;
`endif
               end else if (bus.en_alu_v_i && !bus.en_swap_i) begin
                  // a one-cycle vector unit retires like a scalar op and never enters VWAIT
                  if (VALU_LAT == 1) begin
                     wb_nx  = 1'b1;
                     sel_nx = 3'd1;
                  end else begin
                     state_nx = VWAIT;
                     vcnt_nx  = VW'(VALU_LAT - 1);
                  end
               end else if (bus.en_alu_int_i) begin
                  wb_nx    = 1'b1;
                  sel_nx   = 3'd0;
                  flags_nx = bus.alu_flags_i;
               end else if (bus.en_swap_i) begin
                  wb_nx  = 1'b1;
                  sel_nx = bus.en_alu_v_i ? 3'd3 : 3'd2;
               end
            end
         VWAIT: begin
            // the pulse is registered, so retire one cycle before the count would hit zero
            vcnt_nx = vcnt - 1'b1;
            if (vcnt == VW'(1)) begin
               state_nx = IDLE;
               wb_nx    = 1'b1;
               sel_nx   = 3'd1;
            end
         end
         MWAIT:
            if (bus.mem_ack_i) begin
               state_nx = IDLE;
               wb_nx    = mem_rd;
               sel_nx   = mem_rd ? 3'd4 : bus.wb_sel_o;
               we_nx    = 1'b0;
            end
`ifdef EX_SEQ_TIMEOUT_EN
            else if (tcnt == TW'(MEM_TIMEOUT - 1)) begin
               state_nx = IDLE;
               err_nx   = 1'b1;
               we_nx    = 1'b0;
            end else tcnt_nx = tcnt + 1'b1;
`endif
         default: ;
      endcase
   end
   always_ff @(posedge clk_i)
      if (!rst_i) begin
         state            <= IDLE;
         vcnt             <= '0;
         mem_rd           <= 1'b0;
         bus.mem_req_o    <= 1'b0;
         bus.mem_we_o     <= 1'b0;
         bus.wb_valid_o   <= 1'b0;
         bus.wb_sel_o     <= 3'd0;
         bus.jump_taken_o <= 1'b0;
         bus.jump_addr_o  <= '0;
         bus.flags_o      <= 4'd0;
         bus.halted_o     <= 1'b0;
         bus.err_o        <= 1'b0;
`ifdef EX_SEQ_TIMEOUT_EN
         tcnt             <= '0;
`endif
      end else begin
         state            <= state_nx;
         vcnt             <= vcnt_nx;
         mem_rd           <= rd_nx;
         bus.mem_req_o    <= state_nx == MWAIT;
         bus.mem_we_o     <= we_nx;
         bus.wb_valid_o   <= wb_nx;
         bus.wb_sel_o     <= sel_nx;
         bus.jump_taken_o <= jmp_nx;
         bus.jump_addr_o  <= jaddr_nx;
         bus.flags_o      <= flags_nx;
         bus.halted_o     <= state_nx == HALT;
         bus.err_o        <= err_nx;
`ifdef EX_SEQ_TIMEOUT_EN
         tcnt             <= tcnt_nx;
`endif
      end
endmodule

// File: tb/tb_ex_sequencer.sv
// tb_ex_sequencer: directed and randomized checks of ex_sequencer against a transaction-level model.
module tb_ex_sequencer;
   localparam int VL = 2;
   localparam int JB = 10;
   localparam int MT = 4;
   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   int checks = 0;
   int failures = 0;
   logic [3:0] mf = 4'd0;
   always #5 clk_i = ~clk_i;
   ex_sequencer_if #(.JADDR_BITS(JB)) bus ();
   ex_sequencer #(.VALU_LAT(VL), .JADDR_BITS(JB), .MEM_TIMEOUT(MT)) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .bus(bus)
   );
   typedef struct packed {
      logic [1:0]    cond;
      logic          alu_int, alu_v, mem, jump, swap, fend, nop, rd, wr;
      logic [JB-1:0] addr;
      logic [3:0]    aflags;
   } instr_t;
   task automatic drive(input instr_t i, input logic v);
      bus.issue_valid_i = v;
      bus.cond_i        = i.cond;
      bus.en_alu_int_i  = i.alu_int;
      bus.en_alu_v_i    = i.alu_v;
      bus.en_mem_i      = i.mem;
      bus.en_jump_i     = i.jump;
      bus.en_swap_i     = i.swap;
      bus.flag_end_i    = i.fend;
      bus.flag_nop_i    = i.nop;
      bus.mem_read_i    = i.rd;
      bus.mem_write_i   = i.wr;
      bus.jump_addr_i   = i.addr;
      bus.alu_flags_i   = i.aflags;
   endtask
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask
   // observed: {ready, wb, sel-if-wb, jump, req, we-if-req, halted, flags, err}
   function automatic logic [13:0] snap();
      return {bus.issue_ready_o, bus.wb_valid_o, bus.wb_valid_o ? bus.wb_sel_o : 3'd0, bus.jump_taken_o,
              bus.mem_req_o, bus.mem_req_o & bus.mem_we_o, bus.halted_o, bus.flags_o, bus.err_o};
   endfunction
   function automatic logic [13:0] mk(input logic r, input logic w, input logic [2:0] s, input logic j,
                                      input logic q, input logic e, input logic h, input logic [3:0] f,
                                      input logic er);
      return {r, w, w ? s : 3'd0, j, q, q & e, h, f, er};
   endfunction
   function automatic logic cond_true(input logic [1:0] c, input logic [3:0] f);
      case (c)
         2'd0: return 1'b1;
         2'd1: return f[2];
         2'd2: return !f[2];
         default: return f[3] != f[0];
      endcase
   endfunction
   task automatic test_reset();
      logic [13:0] exp;
      drive('0, 1'b0);
      bus.mem_ack_i = 1'b0;
      rst_i = 1'b0;
      tick();
      tick();
      exp = mk(1, 0, 0, 0, 0, 0, 0, 4'd0, 0);
      checks++; if (snap() !== exp) begin failures++; $display("FAIL reset_state got=%b want=%b", snap(), exp); end
      checks++; if ({bus.jump_addr_o, bus.wb_sel_o, bus.mem_we_o} !== '0) begin failures++; $display("FAIL reset_regs got=%h want=0", {bus.jump_addr_o, bus.wb_sel_o, bus.mem_we_o}); end
      rst_i = 1'b1;
      tick();
      checks++; if (snap() !== exp) begin failures++; $display("FAIL reset_release got=%b want=%b", snap(), exp); end
      mf = 4'd0;
   endtask
   task automatic test_alu_flags();
      instr_t i = '0;
      logic [13:0] exp;
      i.alu_int = 1'b1;
      i.aflags = 4'b0100;
      drive(i, 1'b1);
      tick();
      bus.issue_valid_i = 1'b0;
      mf = 4'b0100;
      exp = mk(1, 1, 3'd0, 0, 0, 0, 0, mf, 0);
      checks++; if (snap() !== exp) begin failures++; $display("FAIL alu_wb got=%b want=%b", snap(), exp); end
      tick();
      exp = mk(1, 0, 0, 0, 0, 0, 0, mf, 0);
      checks++; if (snap() !== exp) begin failures++; $display("FAIL alu_pulse_end got=%b want=%b", snap(), exp); end
   endtask
   task automatic test_jump_cond();
      instr_t i = '0;
      logic [13:0] exp;
      i.jump = 1'b1;
      i.cond = 2'b10;
      i.addr = JB'(10'h155);
      drive(i, 1'b1);
      tick();
      exp = mk(1, 0, 0, 0, 0, 0, 0, mf, 0);
      checks++; if (snap() !== exp) begin failures++; $display("FAIL jump_not_taken got=%b want=%b", snap(), exp); end
      i.cond = 2'b01;
      drive(i, 1'b1);
      tick();
      bus.issue_valid_i = 1'b0;
      exp = mk(1, 0, 0, 1, 0, 0, 0, mf, 0);
      checks++; if (snap() !== exp) begin failures++; $display("FAIL jump_taken got=%b want=%b", snap(), exp); end
      checks++; if (bus.jump_addr_o !== JB'(10'h155)) begin failures++; $display("FAIL jump_addr got=%h want=155", bus.jump_addr_o); end
      tick();
      exp = mk(1, 0, 0, 0, 0, 0, 0, mf, 0);
      checks++; if (snap() !== exp) begin failures++; $display("FAIL jump_pulse_end got=%b want=%b", snap(), exp); end
   endtask
   task automatic test_back_to_back_vector();
      instr_t i = '0;
      logic [13:0] exp;
      i.alu_v = 1'b1;
      drive(i, 1'b1);
      tick();
      for (int k = 1; k < VL; k++) begin
         exp = mk(0, 0, 0, 0, 0, 0, 0, mf, 0);
         checks++; if (snap() !== exp) begin failures++; $display("FAIL vec1_busy got=%b want=%b", snap(), exp); end
         tick();
      end
      exp = mk(1, 1, 3'd1, 0, 0, 0, 0, mf, 0);
      checks++; if (snap() !== exp) begin failures++; $display("FAIL vec1_wb got=%b want=%b", snap(), exp); end
      tick();
      bus.issue_valid_i = 1'b0;
      for (int k = 1; k < VL; k++) begin
         exp = mk(0, 0, 0, 0, 0, 0, 0, mf, 0);
         checks++; if (snap() !== exp) begin failures++; $display("FAIL vec2_busy got=%b want=%b", snap(), exp); end
         tick();
      end
      exp = mk(1, 1, 3'd1, 0, 0, 0, 0, mf, 0);
      checks++; if (snap() !== exp) begin failures++; $display("FAIL vec2_wb got=%b want=%b", snap(), exp); end
   endtask
   task automatic test_mem();
      instr_t i = '0;
      logic [13:0] exp;
      for (int w = 0; w < 2; w++) begin
         i.mem = 1'b1;
         i.wr = w[0];
         i.rd = !w[0];
         drive(i, 1'b1);
         tick();
         bus.issue_valid_i = 1'b0;
         for (int k = 1; k <= 3; k++) begin
            exp = mk(0, 0, 0, 0, 1, i.wr, 0, mf, 0);
            checks++; if (snap() !== exp) begin failures++; $display("FAIL mem_req%0d got=%b want=%b", k, snap(), exp); end
            bus.mem_ack_i = (k == 3);
            tick();
            bus.mem_ack_i = 1'b0;
         end
         exp = mk(1, i.rd, 3'd4, 0, 0, 0, 0, mf, 0);
         checks++; if (snap() !== exp) begin failures++; $display("FAIL mem_done_w%0d got=%b want=%b", w, snap(), exp); end
      end
   endtask
`ifdef EX_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      instr_t i = '0;
      logic [13:0] exp;
      i.mem = 1'b1;
      i.rd = 1'b1;
      drive(i, 1'b1);
      tick();
      bus.issue_valid_i = 1'b0;
      for (int k = 1; k <= MT; k++) begin
         exp = mk(0, 0, 0, 0, 1, 0, 0, mf, 0);
         checks++; if (snap() !== exp) begin failures++; $display("FAIL tmo_req%0d got=%b want=%b", k, snap(), exp); end
         tick();
      end
      exp = mk(1, 0, 0, 0, 0, 0, 0, mf, 1);
      checks++; if (snap() !== exp) begin failures++; $display("FAIL tmo_abort got=%b want=%b", snap(), exp); end
      tick();
      checks++; if (snap() !== exp) begin failures++; $display("FAIL tmo_sticky got=%b want=%b", snap(), exp); end
      rst_i = 1'b0;
      tick();
      rst_i = 1'b1;
      mf = 4'd0;
      exp = mk(1, 0, 0, 0, 0, 0, 0, mf, 0);
      checks++; if (snap() !== exp) begin failures++; $display("FAIL tmo_reset got=%b want=%b", snap(), exp); end
   endtask
`else
   task automatic test_no_timeout();
      instr_t i = '0;
      logic [13:0] exp;
      i.mem = 1'b1;
      i.rd = 1'b1;
      drive(i, 1'b1);
      tick();
      bus.issue_valid_i = 1'b0;
      repeat (3 * MT) tick();
      exp = mk(0, 0, 0, 0, 1, 0, 0, mf, 0);
      checks++; if (snap() !== exp) begin failures++; $display("FAIL mem_wait_long got=%b want=%b", snap(), exp); end
      bus.mem_ack_i = 1'b1;
      tick();
      bus.mem_ack_i = 1'b0;
      exp = mk(1, 1, 3'd4, 0, 0, 0, 0, mf, 0);
      checks++; if (snap() !== exp) begin failures++; $display("FAIL mem_wait_done got=%b want=%b", snap(), exp); end
   endtask
`endif
   task automatic test_halt();
      instr_t i = '0;
      logic [13:0] exp;
      i.fend = 1'b1;
      i.cond = 2'b01;
      drive(i, 1'b1);
      for (int k = 0; k < 3; k++) begin
         tick();
         exp = mk(0, 0, 0, 0, 0, 0, 1, mf, 0);
         checks++; if (snap() !== exp) begin failures++; $display("FAIL halt_hold%0d got=%b want=%b", k, snap(), exp); end
      end
      rst_i = 1'b0;
      tick();
      rst_i = 1'b1;
      bus.issue_valid_i = 1'b0;
      mf = 4'd0;
      exp = mk(1, 0, 0, 0, 0, 0, 0, mf, 0);
      checks++; if (snap() !== exp) begin failures++; $display("FAIL halt_reset got=%b want=%b", snap(), exp); end
   endtask
   task automatic test_reset_midflight();
      instr_t i = '0;
      logic [13:0] exp;
      for (int m = 0; m < 2; m++) begin
         i = '0;
         i.alu_v = (m == 0);
         i.mem = (m == 1);
         i.rd = 1'b1;
         drive(i, 1'b1);
         tick();
         bus.issue_valid_i = 1'b0;
         rst_i = 1'b0;
         tick();
         rst_i = 1'b1;
         mf = 4'd0;
         exp = mk(1, 0, 0, 0, 0, 0, 0, mf, 0);
         checks++; if (snap() !== exp) begin failures++; $display("FAIL midrst%0d got=%b want=%b", m, snap(), exp); end
         bus.mem_ack_i = 1'b1;
         tick();
         bus.mem_ack_i = 1'b0;
         checks++; if (snap() !== exp) begin failures++; $display("FAIL midrst%0d_quiet got=%b want=%b", m, snap(), exp); end
      end
   endtask
   task automatic test_random(input int n);
      instr_t i;
      logic [13:0] exp;
      int kind;
      int d;
      for (int t = 0; t < n; t++) begin
         i.cond    = 2'($urandom);
         i.alu_int = 1'($urandom);
         i.alu_v   = 1'($urandom);
         i.mem     = 1'($urandom);
         i.jump    = ($urandom_range(0, 3) == 0);
         i.swap    = 1'($urandom);
         i.fend    = ($urandom_range(0, 24) == 0);
         i.nop     = ($urandom_range(0, 7) == 0);
         i.wr      = 1'($urandom);
         i.rd      = !i.wr;
         i.addr    = JB'($urandom);
         i.aflags  = 4'($urandom);
         d = $urandom_range(1, MT);
         // 0 silent, 1 end, 2 jump, 3 mem, 4 vector, 5 scalar, 6 swap
         kind = i.fend ? 1 : (i.nop || !cond_true(i.cond, mf)) ? 0 : i.jump ? 2 : i.mem ? 3 :
                (i.alu_v && !i.swap) ? 4 : i.alu_int ? 5 : i.swap ? 6 : 0;
         drive(i, 1'b1);
         tick();
         bus.issue_valid_i = 1'b0;
         case (kind)
            1: begin
               exp = mk(0, 0, 0, 0, 0, 0, 1, mf, 0);
               checks++; if (snap() !== exp) begin failures++; $display("FAIL rnd%0d_end got=%b want=%b", t, snap(), exp); end
               rst_i = 1'b0;
               tick();
               rst_i = 1'b1;
               mf = 4'd0;
               exp = mk(1, 0, 0, 0, 0, 0, 0, mf, 0);
            end
            2: begin
               checks++; if (bus.jump_addr_o !== i.addr) begin failures++; $display("FAIL rnd%0d_jaddr got=%h want=%h", t, bus.jump_addr_o, i.addr); end
               exp = mk(1, 0, 0, 1, 0, 0, 0, mf, 0);
            end
            3: begin
               for (int k = 1; k <= d; k++) begin
                  exp = mk(0, 0, 0, 0, 1, i.wr, 0, mf, 0);
                  checks++; if (snap() !== exp) begin failures++; $display("FAIL rnd%0d_memreq got=%b want=%b", t, snap(), exp); end
                  bus.mem_ack_i = (k == d);
                  tick();
                  bus.mem_ack_i = 1'b0;
               end
               exp = mk(1, i.rd, 3'd4, 0, 0, 0, 0, mf, 0);
            end
            4: begin
               for (int k = 1; k < VL; k++) begin
                  exp = mk(0, 0, 0, 0, 0, 0, 0, mf, 0);
                  checks++; if (snap() !== exp) begin failures++; $display("FAIL rnd%0d_vbusy got=%b want=%b", t, snap(), exp); end
                  tick();
               end
               exp = mk(1, 1, 3'd1, 0, 0, 0, 0, mf, 0);
            end
            5: begin
               mf = i.aflags;
               exp = mk(1, 1, 3'd0, 0, 0, 0, 0, mf, 0);
            end
            6: exp = mk(1, 1, i.alu_v ? 3'd3 : 3'd2, 0, 0, 0, 0, mf, 0);
            default: exp = mk(1, 0, 0, 0, 0, 0, 0, mf, 0);
         endcase
         checks++; if (snap() !== exp) begin failures++; $display("FAIL rnd%0d_k%0d got=%b want=%b", t, kind, snap(), exp); end
         if ($urandom_range(0, 3) == 0) begin
            bus.mem_ack_i = 1'($urandom);
            tick();
            bus.mem_ack_i = 1'b0;
            exp = mk(1, 0, 0, 0, 0, 0, 0, mf, 0);
            checks++; if (snap() !== exp) begin failures++; $display("FAIL rnd%0d_gap got=%b want=%b", t, snap(), exp); end
         end
      end
   endtask
   initial begin
      test_reset();
      test_alu_flags();
      test_jump_cond();
      test_back_to_back_vector();
      test_mem();
`ifdef EX_SEQ_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_halt();
      test_reset_midflight();
      test_random(400);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ex_sequencer.md
# ex_sequencer

Execute-stage controller that sits between decode and the execute functional units (scalar ALU, clocked vector ALU, scalar and vector swappers, data memory port). It accepts one decoded instruction at a time over a valid/ready handshake and evaluates its 2-bit condition against a held flags register. It then sequences the selected unit through its latency and emits one registered writeback-select pulse, jump redirect or halt. It supplies the condition unit the execute stage currently lacks.

## Interface
- VALU_LAT, 2, vector ALU result latency in cycles (≥1)
- JADDR_BITS, 10, jump address width
- MEM_TIMEOUT, 255, max cycles waiting for mem_ack_i (used only with EX_SEQ_TIMEOUT_EN)

- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-low
- issue_valid_i  in  1  decoded instruction present
- issue_ready_o  out  1  sequencer can accept
- cond_i  in  2  00 always, 01 Z=1, 10 Z=0, 11 N≠V
- en_alu_int_i, en_alu_v_i, en_mem_i, en_jump_i, en_swap_i  in  1 each  unit enables
- flag_end_i, flag_nop_i  in  1 each  end-of-program / no-op
- mem_read_i, mem_write_i  in  1 each  memory direction
- jump_addr_i  in  JADDR_BITS  jump target
- alu_flags_i  in  4  scalar ALU flags {N,Z,C,V}, combinational from current operands
- mem_req_o  out  1  memory request, held until ack
- mem_we_o  out  1  1 = write, valid with mem_req_o
- mem_ack_i  in  1  memory completion
- wb_valid_o  out  1  one-cycle writeback pulse
- wb_sel_o  out  3  0 ialu, 1 valu, 2 iswa, 3 vswa, 4 mem
- jump_taken_o  out  1  one-cycle redirect pulse
- jump_addr_o  out  JADDR_BITS  redirect target
- flags_o  out  4  flags register
- halted_o  out  1  program ended
- err_o  out  1  memory timeout (sticky; 0 when macro off)

## Operation
- States: IDLE, VWAIT, MWAIT, HALT. Reset → IDLE.
- issue_ready_o = (state == IDLE). Accept = issue_valid_i & issue_ready_o.
- Condition evaluated at accept against flags_o (pre-update value). Cond false or flag_nop_i: instruction retires silently (no wb, jump, mem or flags change), stays IDLE.
- Class priority when several set: end > jump > mem > vector ALU > scalar ALU > swap.
- End: → HALT; halted_o=1; ready=0 until reset. End is unconditional (cond ignored).
- Jump: jump_taken_o and jump_addr_o registered next cycle; stay IDLE.
- Mem: → MWAIT; mem_req_o=1, mem_we_o=mem_write_i from next cycle until ack sampled. On ack → IDLE; read gives wb_valid_o with sel 4 next cycle; write gives no wb.
- Vector ALU (en_alu_v_i & !en_swap_i): → VWAIT; down-counter loaded VALU_LAT−1; wb sel 1 when count reaches 0 → IDLE.
- Scalar ALU: wb sel 0 next cycle; flags_o ← alu_flags_i at accept edge.
- Swap: sel 3 if en_alu_v_i else 2; wb next cycle.
- Flags change only on executed scalar ALU ops.

## Timing
- Reset values: issue_ready_o=1 after reset released, all pulses 0, mem_req_o=0, mem_we_o=0, flags_o=0, jump_addr_o=0, halted_o=0, err_o=0, wb_sel_o=0.
- All outputs registered except issue_ready_o (state decode).
- Single-cycle classes: back-to-back accept every cycle; result pulse at accept+1.
- Vector: wb at accept+VALU_LAT; next accept earliest same cycle as wb pulse when VALU_LAT≥2.
- Mem: ack on first req cycle → wb at accept+2; ack while not requesting ignored.
- Reset low mid-VWAIT/MWAIT/HALT: next edge returns to IDLE, drops mem_req_o, no pending pulse emitted.

## Configuration
- EX_SEQ_TIMEOUT_EN defined: counter in MWAIT; after MEM_TIMEOUT cycles without ack, drop mem_req_o, set err_o (sticky until reset), → IDLE, no wb.
- Undefined: MWAIT waits indefinitely; err_o tied 0.

## Test plan
- Reset, then scalar ALU always-cond, alu_flags_i=0100 → wb sel 0 at +1, flags_o=0100.
- With flags_o Z=1, jump cond 10, addr 0x155 → no jump_taken_o; cond 01 → jump_taken_o pulse, jump_addr_o=0x155.
- Vector ALU VALU_LAT=2 → ready low 1 cycle, wb sel 1 at accept+2; second vector op on the same cycle as that wb pulse also completes.
- Mem read with ack after 3 req cycles → mem_req_o high 3 cycles, mem_we_o=0, wb sel 4 one cycle after ack; write → no wb.
- flag_end_i with issue_valid_i held → halted_o=1, ready stays 0; rst_i low one cycle → IDLE, halted_o=0.
- EX_SEQ_TIMEOUT_EN, MEM_TIMEOUT=4, no ack → mem_req_o drops after 4 cycles, err_o=1, back to IDLE.
